clcg_sequencer: RTL and testbench

Single-clock controller that sequences two 4-bit LCG datapaths as one combined-LCG (CLCG) bit source. It replaces the two-phase clk1/clk2 drive with one-cycle enable pulses: seed-load (start), sample phase (ph1) and update phase (ph2). It compares the two LCG outputs each iteration to form one random bit, discards a warm-up run, and packs bits into words delivered over a valid/ready handshake. It sits between the LCG datapath pair and the downstream consumer.

---
 rtl/clcg_sequencer_if.sv | 11 +
 rtl/clcg_sequencer.sv | 129 ++++++++++++
 tb/tb_clcg_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clcg_sequencer_if.sv
// Valid/ready word channel from the CLCG sequencer to its consumer.
interface clcg_sequencer_if #(
  parameter int unsigned OUT_W = 8
);
  logic [OUT_W-1:0] rnd_data;
  logic             rnd_valid;
  logic             rnd_ready;

  modport master (output rnd_data, output rnd_valid, input rnd_ready);
  modport slave  (input rnd_data, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/clcg_sequencer.sv
// Sequences two 4-bit LCG datapaths as a combined-LCG bit source and packs
// the comparison bits into words, MSB first, over a valid/ready channel.
module clcg_sequencer #(
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned WARMUP = 4
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       go,
  input  logic       stop,
  input  logic [3:0] x1,
  input  logic [3:0] x2,
  output logic       lcg_clr,
  output logic       lcg_start,
  output logic       lcg_ph1,
  output logic       lcg_ph2,
  output logic       busy,
  clcg_sequencer_if.master rnd
);

  localparam int unsigned BCW = $clog2(OUT_W) + 1;
  localparam int unsigned WCW = $clog2(WARMUP + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SEED1 = 3'd2,
    S_SEED2 = 3'd3,
    S_PH1   = 3'd4,
    S_PH2   = 3'd5,
    S_CMP   = 3'd6,
    S_WAIT  = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_clr;
  logic             r_start;
  logic             r_ph1;
  logic             r_ph2;
  logic             r_busy;
  logic             r_valid;
  logic [OUT_W-1:0] r_data;
  logic [OUT_W-1:0] r_pack;
  logic [BCW-1:0]   r_bitcnt;
  logic [WCW-1:0]   r_warm;
  logic             w_bit;
  logic             w_warming;
  logic             w_last;
  logic             w_abort;
  logic [OUT_W-1:0] w_word;

  assign w_bit     = (x1 > x2);
  assign w_warming = (r_warm < WCW'(WARMUP));
  assign w_last    = (r_bitcnt == BCW'(OUT_W - 1));
  assign w_abort   = stop && (r_state != S_IDLE);
  assign w_word    = r_pack | (OUT_W'(w_bit) << (BCW'(OUT_W - 1) - r_bitcnt));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (go && !stop) w_state_nxt = S_CLR;
      S_CLR:   w_state_nxt = S_SEED1;
      S_SEED1: w_state_nxt = S_SEED2;
      S_SEED2: w_state_nxt = S_PH1;
      S_PH1:   w_state_nxt = S_PH2;
      S_PH2:   w_state_nxt = S_CMP;
      S_CMP:   w_state_nxt = (!w_warming && w_last) ? S_WAIT : S_PH1;
      S_WAIT:  if (rnd.rnd_ready) w_state_nxt = S_PH1;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  // Strobes are decoded from the next state so they are flop outputs yet
  // still line up with the state they belong to.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_clr   <= 1'b0;
      r_start <= 1'b0;
      r_ph1   <= 1'b0;
      r_ph2   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_clr   <= (w_state_nxt == S_CLR);
      r_start <= (w_state_nxt == S_SEED1) || (w_state_nxt == S_SEED2);
      r_ph1   <= (w_state_nxt == S_SEED1) || (w_state_nxt == S_PH1);
      r_ph2   <= (w_state_nxt == S_SEED2) || (w_state_nxt == S_PH2);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_valid <= (w_state_nxt == S_WAIT);
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_data   <= '0;
      r_pack   <= '0;
      r_bitcnt <= '0;
      r_warm   <= '0;
    end else if (w_abort || (r_state == S_CLR)) begin
      r_pack   <= '0;
      r_bitcnt <= '0;
      r_warm   <= '0;
    end else if (r_state == S_CMP) begin
      if (w_warming) begin
        r_warm <= r_warm + WCW'(1);
      end else if (w_last) begin
        r_data   <= w_word;
        r_pack   <= '0;
        r_bitcnt <= '0;
      end else begin
        r_pack   <= w_word;
        r_bitcnt <= r_bitcnt + BCW'(1);
      end
    end
  end

  assign lcg_clr       = r_clr;
  assign lcg_start     = r_start;
  assign lcg_ph1       = r_ph1;
  assign lcg_ph2       = r_ph2;
  assign busy          = r_busy;
  assign rnd.rnd_data  = r_data;
  assign rnd.rnd_valid = r_valid;

endmodule

// File: tb/tb_clcg_sequencer.sv
// Directed bench for clcg_sequencer: strobe timing, packing, warm-up,
// backpressure, stop and asynchronous reset.
module tb_clcg_sequencer;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       go;
  logic       go2;
  logic       stop;
  logic [3:0] x1;
  logic [3:0] x2;
  logic       clr, start, ph1, ph2, busy;
  logic       clr2, start2, ph12, ph22, busy2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mode   = 0;
  int iter   = 0;

  clcg_sequencer_if #(.OUT_W(8)) if1 ();
  clcg_sequencer_if #(.OUT_W(8)) if2 ();

  clcg_sequencer #(.OUT_W(8), .WARMUP(4)) dut (
    .clk1(clk1), .rst(rst), .go(go), .stop(stop), .x1(x1), .x2(x2),
    .lcg_clr(clr), .lcg_start(start), .lcg_ph1(ph1), .lcg_ph2(ph2),
    .busy(busy), .rnd(if1)
  );

  clcg_sequencer #(.OUT_W(8), .WARMUP(0)) dut0 (
    .clk1(clk1), .rst(rst), .go(go2), .stop(stop), .x1(4'd15), .x2(4'd0),
    .lcg_clr(clr2), .lcg_start(start2), .lcg_ph1(ph12), .lcg_ph2(ph22),
    .busy(busy2), .rnd(if2)
  );

  always #5 clk1 = ~clk1;

  // Datapath stand-in: mode 0 = real LCG pair, mode 1 = forced even/odd pattern.
  always @(posedge clk1) begin
    if (clr) begin
      x1 <= 4'd0; x2 <= 4'd0; iter <= 0;
    end else if (ph2 && start) begin
      x1 <= 4'd3; x2 <= 4'd5;
    end else if (ph2) begin
      iter <= iter + 1;
      if (mode == 0) begin
        x1 <= 4'(5 * x1 + 3);
        x2 <= 4'(9 * x2 + 7);
      end else if (iter % 2 == 0) begin
        x1 <= 4'd9; x2 <= 4'd4;
      end else begin
        x1 <= 4'd2; x2 <= 4'd2;
      end
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
    cyc++;
  endtask

  task automatic launch();
    go = 1'b1;
    cyc = 0;
    step();
    go = 1'b0;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic wait_valid(input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      if (if1.rnd_valid) begin
        at = cyc;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    int unsigned outs;
    #1;
    checks++;
    if ({clr, start, ph1, ph2, busy, if1.rnd_valid} !== 6'b0 || if1.rnd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: strobes/busy/valid=%b data=%h, required 000000 00",
               {clr, start, ph1, ph2, busy, if1.rnd_valid}, if1.rnd_data);
    end
    step();
    rst = 1'b1;
    launch();
    while (cyc < 5) step();
    checks++;
    if (ph2 !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_ph2: ph2=%b busy=%b, required 1 1", ph2, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({clr, start, ph1, ph2, busy, if1.rnd_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async: outputs=%b, required 000000",
               {clr, start, ph1, ph2, busy, if1.rnd_valid});
    end
    #1 rst = 1'b1;
    outs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      outs = outs | 32'({clr, start, ph1, ph2, busy, if1.rnd_valid});
    end
    checks++;
    if (outs !== 0) begin
      errors++;
      $display("FAIL reset_idle_hold: or-of-outputs=%b, required 0", outs[5:0]);
    end
  endtask

  task automatic test_pulse_sequence();
    logic [3:0] exp;
    mode = 0;
    launch();
    for (int c = 1; c <= 16; c++) begin
      if (c == 1)      exp = 4'b1000;
      else if (c == 2) exp = 4'b0110;
      else if (c == 3) exp = 4'b0101;
      else if ((c - 4) % 3 == 0) exp = 4'b0010;
      else if ((c - 4) % 3 == 1) exp = 4'b0001;
      else exp = 4'b0000;
      checks++;
      if ({clr, start, ph1, ph2} !== exp || busy !== 1'b1) begin
        errors++;
        $display("FAIL pulse_c%0d: clr/start/ph1/ph2=%b busy=%b, required %b 1",
                 c, {clr, start, ph1, ph2}, busy, exp);
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_bit_packing();
    int at;
    mode = 1;
    if1.rnd_ready = 1'b1;
    launch();
    wait_valid(60, at);
    checks++;
    if (at != 40 || if1.rnd_data !== 8'hAA) begin
      errors++;
      $display("FAIL pack_word1: cycle=%0d data=%h, required 40 aa", at, if1.rnd_data);
    end
    step();
    checks++;
    if (if1.rnd_valid !== 1'b0 || ph1 !== 1'b1) begin
      errors++;
      $display("FAIL pack_accept: valid=%b ph1=%b, required 0 1", if1.rnd_valid, ph1);
    end
    wait_valid(40, at);
    checks++;
    if (at != 65 || if1.rnd_data !== 8'hAA) begin
      errors++;
      $display("FAIL pack_word2: cycle=%0d data=%h, required 65 aa", at, if1.rnd_data);
    end
    go_idle();
  endtask

  task automatic test_warmup();
    int at;
    if2.rnd_ready = 1'b1;
    go2 = 1'b1;
    cyc = 0;
    step();
    go2 = 1'b0;
    at = -1;
    for (int n = 0; n < 60 && at < 0; n++) begin
      if (if2.rnd_valid) at = cyc;
      else step();
    end
    checks++;
    if (at != 28 || if2.rnd_data !== 8'hFF) begin
      errors++;
      $display("FAIL warmup0_word: cycle=%0d data=%h, required 28 ff", at, if2.rnd_data);
    end
  endtask

  task automatic test_backpressure();
    int at;
    int v;
    int p;
    int bad;
    mode = 1;
    if1.rnd_ready = 1'b0;
    launch();
    wait_valid(60, at);
    checks++;
    if (at != 40) begin
      errors++;
      $display("FAIL bp_first_valid: cycle=%0d, required 40", at);
    end
    v = cyc;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (if1.rnd_valid !== 1'b1 || if1.rnd_data !== 8'hAA ||
          {clr, start, ph1, ph2} !== 4'b0 || busy !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: bad cycles=%0d, required 0", bad);
    end
    if1.rnd_ready = 1'b1;
    step();
    checks++;
    if (cyc != v + 11 || ph1 !== 1'b1 || if1.rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ph1=%b valid=%b, required 1 0", ph1, if1.rnd_valid);
    end
    p = cyc;
    wait_valid(40, at);
    checks++;
    if (at != p + 24 || if1.rnd_data !== 8'hAA) begin
      errors++;
      $display("FAIL bp_next_word: cycle=%0d data=%h, required %0d aa", at, if1.rnd_data, p + 24);
    end
    go_idle();
  endtask

  task automatic test_stop_mid_word();
    int at;
    mode = 1;
    if1.rnd_ready = 1'b1;
    launch();
    while (cyc < 20) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || if1.rnd_valid !== 1'b0 || {clr, start, ph1, ph2} !== 4'b0) begin
      errors++;
      $display("FAIL stop_idle: busy=%b valid=%b strobes=%b, required 0 0 0000",
               busy, if1.rnd_valid, {clr, start, ph1, ph2});
    end
    checks++;
    if (if1.rnd_data !== 8'hAA) begin
      errors++;
      $display("FAIL stop_data_kept: data=%h, required aa", if1.rnd_data);
    end
    launch();
    checks++;
    if ({clr, start, ph1, ph2} !== 4'b1000) begin
      errors++;
      $display("FAIL stop_rego_clr: strobes=%b, required 1000", {clr, start, ph1, ph2});
    end
    wait_valid(60, at);
    checks++;
    if (at != 40 || if1.rnd_data !== 8'hAA) begin
      errors++;
      $display("FAIL stop_rego_word: cycle=%0d data=%h, required 40 aa", at, if1.rnd_data);
    end
    go_idle();
  endtask

  initial begin
    rst = 1'b0;
    go = 1'b0;
    go2 = 1'b0;
    stop = 1'b0;
    if1.rnd_ready = 1'b1;
    if2.rnd_ready = 1'b1;
    test_reset();
    test_pulse_sequence();
    test_bit_packing();
    test_warmup();
    test_backpressure();
    test_stop_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
